// File: rtl/sample_scheduler_if.sv
// Triangle-in / sample-group-out bus between upstream setup, the sample scheduler and sampletest.
interface sample_scheduler_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
);
  logic                                   tri_valid;
  logic                                   tri_ready;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in;
  logic [COLORS-1:0][SIGFIG-1:0]          color_in;
  logic [1:0][1:0][SIGFIG-1:0]            bbox_in;
  logic [3:0]                             subsample;
  logic                                   ds_halt;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_out;
  logic [COLORS-1:0][SIGFIG-1:0]          color_out;
  logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_out;
  logic [SAMPS-1:0]                       validSamp;

  modport slave (
    input  tri_valid, tri_in, color_in, bbox_in, subsample, ds_halt,
    output tri_ready, tri_out, color_out, sample_out, validSamp
  );

  modport master (
    output tri_valid, tri_in, color_in, bbox_in, subsample, ds_halt,
    input  tri_ready, tri_out, color_out, sample_out, validSamp
  );
endinterface

// File: rtl/sample_scheduler.sv
// Raster-order sample iterator: walks a triangle's bounding box emitting SAMPS adjacent samples per cycle.
// Latency 1 cycle from accept to first group; ds_halt freezes iteration and outputs, capture still allowed.
module sample_scheduler #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input logic               clk,
  input logic               rst,
  sample_scheduler_if.slave bus
);
  localparam int W = SIGFIG + 1;

  typedef enum logic {S_WAIT, S_ITER} state_t;
  state_t state, state_nxt;

  logic signed [W-1:0] cur_x, cur_y, ll_x, ur_x, ur_y, step_q;
  logic signed [W-1:0] in_llx, in_lly, in_urx, in_ury, step_in;
  logic signed [W-1:0] nx_x, nx_y;
  logic signed [W-1:0] lane_x [SAMPS];
  logic                accept, box_empty, advance, wrap, last_grp, ready_c;

  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_o;
  logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_o;
  logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_o;
  logic [SAMPS-1:0]                       vsamp_o;

  // Coordinates carry one extra bit so a box touching +max never wraps.
  assign in_llx = {bus.bbox_in[0][0][SIGFIG-1], bus.bbox_in[0][0]};
  assign in_lly = {bus.bbox_in[0][1][SIGFIG-1], bus.bbox_in[0][1]};
  assign in_urx = {bus.bbox_in[1][0][SIGFIG-1], bus.bbox_in[1][0]};
  assign in_ury = {bus.bbox_in[1][1][SIGFIG-1], bus.bbox_in[1][1]};

  always_comb begin
    case (bus.subsample)
      4'b0100: step_in = W'(1) << (RADIX - 1);
      4'b0010: step_in = W'(1) << (RADIX - 2);
      4'b0001: step_in = W'(1) << (RADIX - 3);
      default: step_in = W'(1) << RADIX;
    endcase
  end

  assign box_empty = (in_urx < in_llx) || (in_ury < in_lly);
  assign accept    = bus.tri_valid && ready_c;
  assign nx_x      = cur_x + (step_q <<< $clog2(SAMPS));
  assign nx_y      = cur_y + step_q;
  assign wrap      = nx_x > ur_x;
  assign last_grp  = wrap && (nx_y > ur_y);

  always_comb begin
    lane_x[0] = cur_x;
    for (int i = 1; i < SAMPS; i++) lane_x[i] = lane_x[i-1] + step_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_WAIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT: if (accept && !box_empty) state_nxt = S_ITER;
      S_ITER: if (!bus.ds_halt && last_grp) state_nxt = S_WAIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    ready_c = (state == S_WAIT);
    advance = (state == S_ITER) && !bus.ds_halt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_x   <= '0;
      cur_y   <= '0;
      ll_x    <= '0;
      ur_x    <= '0;
      ur_y    <= '0;
      step_q  <= '0;
      tri_q   <= '0;
      color_q <= '0;
    end else if (accept) begin
      cur_x   <= in_llx;
      cur_y   <= in_lly;
      ll_x    <= in_llx;
      ur_x    <= in_urx;
      ur_y    <= in_ury;
      step_q  <= step_in;
      tri_q   <= bus.tri_in;
      color_q <= bus.color_in;
    end else if (advance) begin
      if (wrap) begin
        cur_x <= ll_x;
        cur_y <= nx_y;
      end else begin
        cur_x <= nx_x;
      end
    end
  end

  // Lanes past ur.x are still driven with their location but flagged invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tri_o    <= '0;
      color_o  <= '0;
      sample_o <= '0;
      vsamp_o  <= '0;
    end else if (advance) begin
      tri_o   <= tri_q;
      color_o <= color_q;
      for (int i = 0; i < SAMPS; i++) begin
        sample_o[0][i] <= lane_x[i][SIGFIG-1:0];
        sample_o[1][i] <= cur_y[SIGFIG-1:0];
        vsamp_o[i]     <= (lane_x[i] <= ur_x);
      end
    end else if (state == S_WAIT && !bus.ds_halt) begin
      vsamp_o <= '0;
    end
  end

  assign bus.tri_ready  = ready_c;
  assign bus.tri_out    = tri_o;
  assign bus.color_out  = color_o;
  assign bus.sample_out = sample_o;
  assign bus.validSamp  = vsamp_o;
endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: directed cases plus random boxes against a raster-walk reference model.
module tb_sample_scheduler;
  localparam int SIGFIG = 24, VERTS = 3, AXIS = 3, COLORS = 3, SAMPS = 4;

  typedef struct packed {
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_v;
    logic [COLORS-1:0][SIGFIG-1:0]          col;
    logic [SAMPS-1:0][SIGFIG-1:0]           xs;
    logic [SIGFIG-1:0]                      y;
    logic [SAMPS-1:0]                       vld;
  } grp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sample_scheduler_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS), .SAMPS(SAMPS)) bus ();

  sample_scheduler #(.SIGFIG(SIGFIG), .RADIX(10), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS), .SAMPS(SAMPS))
    dut (.clk(clk), .rst(rst), .bus(bus));

  grp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   seen = 0;
  int   halt_cnt = 0;
  bit   halt_rand = 0;

  function automatic int step_of(input logic [3:0] ss);
    case (ss)
      4'b0100: return 512;
      4'b0010: return 256;
      4'b0001: return 128;
      default: return 1024;
    endcase
  endfunction

  // Reference: plain raster walk over the box, SAMPS samples per group, rows never shared.
  task automatic model_push(input int llx, lly, urx, ury, input logic [3:0] ss,
                            input logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] t,
                            input logic [COLORS-1:0][SIGFIG-1:0] c);
    int st;
    int xv;
    grp_t g;
    st = step_of(ss);
    if (urx < llx || ury < lly) return;
    for (int y = lly; y <= ury; y += st) begin
      for (int x = llx; x <= urx; x += SAMPS * st) begin
        g.tri_v = t;
        g.col   = c;
        g.y     = y[SIGFIG-1:0];
        for (int i = 0; i < SAMPS; i++) begin
          xv       = x + i * st;
          g.xs[i]  = xv[SIGFIG-1:0];
          g.vld[i] = (xv <= urx);
        end
        exp_q.push_back(g);
      end
    end
  endtask

  // A presented group is consumed on any edge where downstream is not halting.
  always @(negedge clk) begin
    grp_t act, g;
    if (rst && bus.validSamp != '0 && !bus.ds_halt) begin
      act.tri_v = bus.tri_out;
      act.col   = bus.color_out;
      act.xs    = bus.sample_out[0];
      act.y     = bus.sample_out[1][0];
      act.vld   = bus.validSamp;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_group got x0=%0d y=%0d vld=%b, none expected",
                 $signed(act.xs[0]), $signed(act.y), act.vld);
      end else begin
        g = exp_q.pop_front();
        if (act !== g || bus.sample_out[1] !== {SAMPS{g.y}}) begin
          mismatched++;
          $display("FAIL group%0d got %h want %h", seen, act, g);
        end
      end
      seen++;
    end
  end

  always @(posedge clk) begin
    #2;
    if (halt_cnt > 0) begin
      bus.ds_halt = 1'b1;
      halt_cnt--;
    end else begin
      bus.ds_halt = halt_rand && ($urandom_range(0, 2) == 0);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Called aligned just after a posedge; returns aligned the same way.
  task automatic send(input int llx, lly, urx, ury, input logic [3:0] ss);
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] t;
    logic [COLORS-1:0][SIGFIG-1:0] c;
    bit rdy;
    int n;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) t[v][a] = SIGFIG'($urandom);
    for (int k = 0; k < COLORS; k++) c[k] = SIGFIG'($urandom);
    bus.tri_in = t;
    bus.color_in = c;
    bus.bbox_in[0][0] = SIGFIG'(llx);
    bus.bbox_in[0][1] = SIGFIG'(lly);
    bus.bbox_in[1][0] = SIGFIG'(urx);
    bus.bbox_in[1][1] = SIGFIG'(ury);
    bus.subsample = ss;
    bus.tri_valid = 1'b1;
    rdy = 0;
    n = 0;
    while (!rdy && n < 2000) begin
      @(negedge clk);
      rdy = bus.tri_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.tri_valid = 1'b0;
    if (!rdy) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout got ready=0 want ready=1 within 2000 cycles");
    end else begin
      model_push(llx, lly, urx, ury, ss, t, c);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && bus.tri_ready && bus.validSamp == '0) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {32'(exp_q.size()), 31'd0, bus.tri_ready}, 64'd1);
  endtask

  task automatic wait_seen(input int target);
    int n;
    n = 0;
    while (seen < target && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wait_group", 64'(seen >= target), 64'd1);
  endtask

  initial begin
    int base, llx, lly, w, h;
    logic [3:0] ss_tab [7];
    ss_tab = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b1100, 4'b0011};
    bus.tri_valid = 1'b0;
    bus.tri_in = '0;
    bus.color_in = '0;
    bus.bbox_in = '0;
    bus.subsample = 4'b1000;
    bus.ds_halt = 1'b0;

    #23;
    check("reset_valid", 64'(bus.validSamp), 64'd0);
    check("reset_ready", 64'(bus.tri_ready), 64'd1);
    check("reset_outs", 64'(|{bus.tri_out, bus.color_out, bus.sample_out}), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Single-point box: one group, only lane 0 valid.
    base = seen;
    send(0, 0, 0, 0, 4'b1000);
    wait_seen(base + 1);
    check("t1_ready_after", 64'(bus.tri_ready), 64'd1);
    wait_idle("t1_idle");

    send(0, 0, 7168, 1024, 4'b1000);
    wait_idle("t2_idle");

    // Halt for 3 cycles while group 2 is presented.
    base = seen;
    send(0, 0, 7168, 1024, 4'b1000);
    wait_seen(base + 1);
    @(posedge clk);
    #1;
    halt_cnt = 3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("t3_frozen", {bus.ds_halt, bus.validSamp, 8'(bus.sample_out[0][0] >> 10), 8'(bus.sample_out[1][0])},
            {1'b1, 4'hf, 8'd4, 8'd0});
    end
    @(posedge clk);
    #1;
    wait_idle("t3_idle");
    check("t3_total", 64'(seen - base), 64'd4);

    // Empty box is dropped.
    base = seen;
    send(2048, 0, 1024, 0, 4'b1000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check("t4_idle", {bus.tri_ready, bus.validSamp}, {1'b1, 4'h0});
    end
    check("t4_nogroup", 64'(seen - base), 64'd0);
    @(posedge clk);
    #1;

    // Reset mid-iteration, then a fresh triangle.
    base = seen;
    send(0, 0, 7168, 1024, 4'b1000);
    wait_seen(base + 1);
    @(posedge clk);
    #1;
    check("t5_group2_live", 64'(bus.validSamp), 64'hf);
    rst = 1'b0;
    #1;
    check("t5_async_clear", 64'(bus.validSamp), 64'd0);
    exp_q.delete();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_ready", 64'(bus.tri_ready), 64'd1);
    send(-1024, 2048, 1024, 2048, 4'b0100);
    wait_idle("t5_idle");

    send(0, 0, 896, 896, 4'b0001);
    wait_idle("t6_idle");

    // Box hugging the positive coordinate limit.
    send(8388607 - 2500, 100, 8388607, 1100, 4'b1000);
    wait_idle("max_idle");

    halt_rand = 1;
    for (int r = 0; r < 30; r++) begin
      llx = $urandom_range(0, 4000) - 2000;
      lly = $urandom_range(0, 4000) - 2000;
      w   = $urandom_range(0, 2500) - 200;
      h   = $urandom_range(0, 1500) - 100;
      send(llx, lly, llx + w, lly + h, ss_tab[$urandom_range(0, 6)]);
    end
    wait_idle("rand_idle");
    halt_rand = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
